// File: rtl/risc_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : risc_trace_buffer
// Purpose  : FWFT retirement-trace FIFO with sequence numbering, overflow
//            counting and an optional PC-match stop trigger, enabled by
//            defining RISC_TRACE_TRIGGER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module risc_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int POST  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    input  logic [31:0]                in_result,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_result,
    output logic [15:0]                out_seq,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                overflow_cnt,
    input  logic                       trig_arm,
    input  logic [31:0]                trig_pc,
    output logic                       triggered
);

    localparam int             PW     = $clog2(DEPTH);
    localparam logic [PW:0]    C_FULL = (PW+1)'(DEPTH);

    logic [31:0]   r_mem_pc     [DEPTH];
    logic [31:0]   r_mem_instr  [DEPTH];
    logic [31:0]   r_mem_result [DEPTH];
    logic [15:0]   r_mem_seq    [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic [15:0]   r_ovf;
    logic [15:0]   r_seq;

    logic w_capture_en;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // flush masks push/pop so it wins over both in the same cycle
    assign out_valid = (r_count != '0);
    assign w_full    = (r_count == C_FULL);
    assign w_pop     = out_valid && out_ready && !flush;
    assign w_push    = in_valid && w_capture_en && (!w_full || w_pop) && !flush;
    assign w_drop    = in_valid && w_capture_en && w_full && !w_pop && !flush;

    assign out_pc       = r_mem_pc[r_rd_ptr];
    assign out_instr    = r_mem_instr[r_rd_ptr];
    assign out_result   = r_mem_result[r_rd_ptr];
    assign out_seq      = r_mem_seq[r_rd_ptr];
    assign count        = r_count;
    assign overflow_cnt = r_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]     <= '0;
                r_mem_instr[i]  <= '0;
                r_mem_result[i] <= '0;
                r_mem_seq[i]    <= '0;
            end
        end else if (w_push) begin
            r_mem_pc[r_wr_ptr]     <= in_pc;
            r_mem_instr[r_wr_ptr]  <= in_instr;
            r_mem_result[r_wr_ptr] <= in_result;
            r_mem_seq[r_wr_ptr]    <= r_seq;
        end
    end

    // Sequence numbers advance on every retirement, even dropped or discarded ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seq <= '0;
        end else if (in_valid) begin
            r_seq <= r_seq + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_ovf != 16'hFFFF)) r_ovf <= r_ovf + 16'd1;
        end
    end

`ifdef RISC_TRACE_TRIGGER_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_post;
    logic [7:0] w_post_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_post  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_post  <= w_post_nxt;
        end
    end

    // Trigger state is frozen during flush
    always_comb begin
        w_state_nxt = r_state;
        w_post_nxt  = r_post;
        if (!flush) begin
            case (r_state)
                S_IDLE: if (trig_arm) w_state_nxt = S_ARMED;
                S_ARMED: begin
                    if ((w_push || w_drop) && (in_pc == trig_pc)) begin
                        w_post_nxt  = 8'(POST);
                        w_state_nxt = S_POST;
                    end
                end
                S_POST: begin
                    if (w_push) begin
                        w_post_nxt = r_post - 8'd1;
                        if (r_post == 8'd1) w_state_nxt = S_DONE;
                    end
                end
                S_DONE: if (trig_arm) w_state_nxt = S_ARMED;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_capture_en = (r_state != S_DONE);
    assign triggered    = (r_state == S_DONE);
`else
    logic w_unused_trig;
    assign w_unused_trig = ^{trig_arm, trig_pc};
    assign w_capture_en  = 1'b1;
    assign triggered     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_risc_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_trace_buffer
// Purpose  : Directed plus randomized bench for risc_trace_buffer against a
//            queue-based record model (trigger steps need RISC_TRACE_TRIGGER_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc_trace_buffer;

    localparam int DEPTH = 16;
    localparam int POST  = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic [31:0] in_result;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_result;
    logic [15:0] out_seq;
    logic [4:0]  count;
    logic [15:0] overflow_cnt;
    logic        trig_arm;
    logic [31:0] trig_pc;
    logic        triggered;

    risc_trace_buffer #(.DEPTH(DEPTH), .POST(POST)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_result    (in_result),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_result   (out_result),
        .out_seq      (out_seq),
        .count        (count),
        .overflow_cnt (overflow_cnt),
        .trig_arm     (trig_arm),
        .trig_pc      (trig_pc),
        .triggered    (triggered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] res;
        logic [15:0] seq;
    } rec_t;

    rec_t        q[$];
    logic [15:0] m_seq;
    logic [15:0] m_ovf;
    bit          m_armed;
    int          m_left;
    bit          m_done;
    logic [31:0] last_pc;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
        chk("triggered", 32'(triggered), 32'(m_done));
        if (q.size() != 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", out_instr, q[0].instr);
            chk("out_result", out_result, q[0].res);
            chk("out_seq", 32'(out_seq), 32'(q[0].seq));
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge
    task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                        input logic fl, input logic arm);
        rec_t r;
        bit   mpop;
        bit   full;
        bit   cap;
        bit   pushed;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = $urandom;
        in_result = $urandom;
        out_ready = rdy;
        flush     = fl;
        trig_arm  = arm;
        r.pc = pc; r.instr = in_instr; r.res = in_result; r.seq = m_seq;
        cap    = !m_done;
        mpop   = (q.size() != 0) && rdy;
        pushed = 1'b0;
        if (fl) begin
            q.delete();
            m_ovf = '0;
        end else begin
            full = (q.size() == DEPTH);
            if (mpop) begin
                last_pc = q[0].pc;
                void'(q.pop_front());
            end
            if (v && cap) begin
                pushed = !full || mpop;
                if (pushed) q.push_back(r);
                else if (m_ovf != 16'hFFFF) m_ovf++;
            end
`ifdef RISC_TRACE_TRIGGER_EN
            if (m_armed) begin
                if (v && cap && pc == trig_pc) begin
                    m_armed = 1'b0;
                    m_left  = POST;
                end
            end else if (m_left > 0) begin
                if (pushed) begin
                    m_left--;
                    if (m_left == 0) m_done = 1'b1;
                end
            end else if (arm) begin
                m_armed = 1'b1;
                m_done  = 1'b0;
            end
`endif
        end
        if (v) m_seq++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted between edges, checked before any edge
    task automatic do_reset();
        rst = 1'b0;
        q.delete();
        m_seq = '0; m_ovf = '0; m_armed = 1'b0; m_left = 0; m_done = 1'b0;
        #1;
        check_all();
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_seq", 32'(out_seq), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; last_pc = '0;
        rst = 1'b1; in_valid = 1'b1; in_pc = 32'h100; in_instr = '0; in_result = '0;
        flush = 1'b0; out_ready = 1'b0; trig_arm = 1'b0; trig_pc = '0;
        @(posedge clk);
        #1;
        do_reset();

        // First record and buffering order
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("first_seq", 32'(out_seq), 32'h0);
        chk("first_pc", out_pc, 32'h0);
        step(1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0);
        chk("buf_count", 32'(count), 32'd3);
        chk("buf_head", out_pc, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("buf_empty", 32'(out_valid), 32'd0);

        // Overflow then full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_cnt", 32'(overflow_cnt), 32'd4);
        chk("ovf_head_seq", 32'(out_seq), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
        chk("fullpp_count", 32'(count), 32'd16);
        chk("fullpp_ovf", 32'(overflow_cnt), 32'd4);
        chk("fullpp_seq", 32'(out_seq), 32'd5);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("entry16_seq", 32'(out_seq), 32'd15);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("next_acc_seq", 32'(out_seq), 32'd20);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush alongside a push
        do_reset();
        for (int i = 0; i < 18; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd9);
        chk("pre_flush_ovf", 32'(overflow_cnt), 32'd2);
        step(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_ovf", 32'(overflow_cnt), 32'd0);
        step(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
        chk("flush_seq_cont", 32'(out_seq), 32'd19);

        // Randomized traffic with occasional flushes
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0, 1'b0);
        end

`ifdef RISC_TRACE_TRIGGER_EN
        do_reset();
        trig_pc = 32'h20;
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= 16; i++) step(1'b1, 32'(i * 4), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        for (int k = 0; k < 20 && out_valid; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("trig_last_pc", last_pc, 32'h30);
        chk("trig_ovf", 32'(overflow_cnt), 32'd0);
        chk("trig_done", 32'(triggered), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("trig_rearm", 32'(triggered), 32'd0);
`endif

        // Reset while records are held
        for (int i = 0; i < 5; i++) step(1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        do_reset();
        step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
        chk("post_rst_seq", 32'(out_seq), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
